// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
package imem_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  // MIPS nop (sll $0,$0,0); returned after reset and on faulted fetches.
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_FLT  = 2'd3
  } state_t;

  // A fetch address is bad when it is not word aligned or when it points
  // past the end of a 2**aw word array.
  function automatic logic addr_bad(input logic [PC_W-1:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port for program load, one combinational
// read port. A same-cycle write to the word being read is forwarded so the
// reader sees the new value (write-first).
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [2**ADDR_W];

  // Program-load write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read with forwarding of a write landing on the same edge.
  always_comb begin
    rd_data = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts word fetches over Req/Ack, inserts
// WAIT_CYC wait states to model slow memory, and flags bad addresses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no fetch outstanding, Req accepted
//   ST_WAIT | counting wait states, Req/Addr ignored
//   ST_RESP | next edge registers Ack + data, Req accepted as next fetch
//   ST_FLT  | next edge registers Ack + Fault + nop, Req accepted
module imem_responder
  import imem_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                WAIT_CYC   = 2,
  parameter logic [INST_W-1:0] RESET_INST = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic [PC_W-1:0]   Addr,
  output logic              Ack,
  output logic [INST_W-1:0] Inst,
  output logic              Fault,
  output logic              Busy,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [INST_W-1:0] LdData
);

  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("imem_responder: WAIT_CYC must be in 0..15");
  end

  // Counter reload leaves WAIT_CYC-1 more cycles in ST_WAIT after entry.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t            state;
  state_t            accept_state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] word_q;
  logic [INST_W-1:0] rd_data;
  logic              take;

  imem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (Clk),
    .wr_en   (LdEn),
    .wr_addr (LdAddr),
    .wr_data (LdData),
    .rd_addr (word_q),
    .rd_data (rd_data)
  );

  // Destination state for a freshly accepted fetch.
  always_comb begin
    accept_state = ST_WAIT;
    if (addr_bad(Addr, ADDR_W)) begin
      accept_state = ST_FLT;
    end else if (WAIT_CYC == 0) begin
      accept_state = ST_RESP;
    end
  end

  // A new request is taken whenever the responder is not mid-wait, which
  // lets a held Req chain fetches back to back out of ST_RESP/ST_FLT.
  assign take = Req && (state != ST_WAIT);
  assign Busy = (state != ST_IDLE);

  // Fetch FSM, wait counter, latched word address and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      word_q <= '0;
      Ack    <= 1'b0;
      Fault  <= 1'b0;
      Inst   <= RESET_INST;
    end else begin
      Ack   <= 1'b0;
      Fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          Ack   <= 1'b1;
          Inst  <= rd_data;
          state <= ST_IDLE;
        end
        ST_FLT: begin
          Ack   <= 1'b1;
          Fault <= 1'b1;
          Inst  <= RESET_INST;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (take) begin
        state  <= accept_state;
        cnt    <= WAIT_LOAD;
        word_q <= Addr[ADDR_W+1:2];
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios followed by
// randomized fetches/loads checked against a word-array reference model.
module tb_imem_responder;

  localparam int          ADDR_W   = 8;
  localparam int          WAIT_CYC = 2;
  localparam int          DEPTH    = 2**ADDR_W;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic              Clk    = 1'b0;
  logic              Reset  = 1'b1;
  logic              Req    = 1'b0;
  logic [31:0]       Addr   = 32'h0;
  logic              LdEn   = 1'b0;
  logic [ADDR_W-1:0] LdAddr = '0;
  logic [31:0]       LdData = 32'h0;
  logic              Ack;
  logic              Fault;
  logic              Busy;
  logic [31:0]       Inst;

  int checks = 0;
  int errors = 0;

  logic [31:0] shadow [DEPTH];

  always #5 Clk = ~Clk;

  imem_responder #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYC   (WAIT_CYC),
    .RESET_INST (NOP)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .Addr   (Addr),
    .Ack    (Ack),
    .Inst   (Inst),
    .Fault  (Fault),
    .Busy   (Busy),
    .LdEn   (LdEn),
    .LdAddr (LdAddr),
    .LdData (LdData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: byte address must be word aligned and inside the array.
  function automatic bit exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic int exp_lat(input logic [31:0] a);
    return exp_fault(a) ? 1 : WAIT_CYC + 1;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int wa, input logic [31:0] d);
    LdEn   = 1'b1;
    LdAddr = ADDR_W'(wa);
    LdData = d;
    step();
    LdEn = 1'b0;
    shadow[wa] = d;
  endtask

  // One isolated fetch. ld_at selects the post-accept cycle (0-based) in
  // which the fetched word is rewritten; the last cycle lands the write on
  // the response edge itself. Out-of-range ld_at means no write.
  task automatic fetch(input logic [31:0] a, input int ld_at, input logic [31:0] ld_data,
                       input string tag);
    int lat;
    bit f;
    lat = exp_lat(a);
    f   = exp_fault(a);
    Req  = 1'b1;
    Addr = a;
    step();
    Req  = 1'b0;
    Addr = $urandom;
    for (int i = 0; i < lat; i++) begin
      chk({tag, ":busy"}, 32'(Busy), 32'd1);
      chk({tag, ":early_ack"}, 32'(Ack), 32'd0);
      if (i == ld_at && !f) begin
        LdEn   = 1'b1;
        LdAddr = ADDR_W'(word_of(a));
        LdData = ld_data;
        shadow[word_of(a)] = ld_data;
      end
      step();
      LdEn = 1'b0;
    end
    chk({tag, ":ack"}, 32'(Ack), 32'd1);
    chk({tag, ":fault"}, 32'(Fault), 32'(f));
    chk({tag, ":inst"}, Inst, f ? NOP : shadow[word_of(a)]);
    chk({tag, ":busy_done"}, 32'(Busy), 32'd0);
    step();
    chk({tag, ":ack_pulse"}, 32'(Ack), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    int ld_at;

    // Reset values.
    step();
    chk("rst:ack", 32'(Ack), 32'd0);
    chk("rst:fault", 32'(Fault), 32'd0);
    chk("rst:busy", 32'(Busy), 32'd0);
    chk("rst:inst", Inst, NOP);
    Reset = 1'b0;
    step();

    for (int w = 0; w < DEPTH; w++) begin
      load(w, $urandom);
    end

    // Basic fetch with wait states.
    load(3, 32'h2008_0005);
    fetch(32'h0000_000C, -1, 32'h0, "basic");

    // Misaligned and out-of-range addresses.
    fetch(32'h0000_0006, -1, 32'h0, "misalign");
    fetch(32'h0000_0400, -1, 32'h0, "oor");
    fetch(32'h8000_0000, -1, 32'h0, "oor_hi");
    fetch(32'h0000_03FC, -1, 32'h0, "last_word");

    // Back-to-back with Req held high; Addr updated only after each accept.
    load(0, 32'hAAAA_0000);
    load(1, 32'hBBBB_1111);
    load(2, 32'hCCCC_2222);
    Req  = 1'b1;
    Addr = 32'h0;
    step();
    Addr = 32'h4;
    for (int n = 0; n < 12; n++) begin
      bit ack_exp;
      ack_exp = (n == 3) || (n == 6) || (n == 9);
      chk("b2b:ack", 32'(Ack), 32'(ack_exp));
      chk("b2b:busy", 32'(Busy), 32'(n < 9));
      if (ack_exp) begin
        chk("b2b:inst", Inst, shadow[n / 3 - 1]);
        chk("b2b:fault", 32'(Fault), 32'd0);
      end
      if (n == 3) Addr = 32'h8;
      if (n == 6) begin
        Req  = 1'b0;
        Addr = 32'hFFFF_FFFF;
      end
      step();
    end

    // Reset while a fetch is waiting.
    Req  = 1'b1;
    Addr = 32'h0000_0010;
    step();
    Req = 1'b0;
    step();
    chk("rstwait:busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("rstwait:busy", 32'(Busy), 32'd0);
    chk("rstwait:ack", 32'(Ack), 32'd0);
    chk("rstwait:inst", Inst, NOP);
    step();
    step();
    Reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      chk("rstwait:no_ack", 32'(Ack), 32'd0);
      chk("rstwait:idle", 32'(Busy), 32'd0);
      step();
    end
    fetch(32'h0000_0010, -1, 32'h0, "after_rst");
    fetch(32'h0000_000C, -1, 32'h0, "retained");

    // Program-load writes racing a fetch of the same word.
    load(5, 32'h1111_1111);
    fetch(32'h0000_0014, 0, 32'hDEAD_BEEF, "ld_wait");
    fetch(32'h0000_0018, WAIT_CYC, 32'hCAFE_F00D, "ld_resp_edge");

    // Randomized fetches mixed with loads.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2:    a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        default: begin
          a = $urandom;
          if (a < 32'(4 * DEPTH)) a = a + 32'(4 * DEPTH);
        end
      endcase
      ld_at = $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, DEPTH - 1), $urandom);
      fetch(a, ld_at, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
